// File: rtl/sobel_pkg.sv
// sobel_pkg: shared sizes, output codes, FSM states and gradient helpers for the Sobel edge filter
package sobel_pkg;

    localparam int PIC_H_DEF = 180;
    localparam int PIC_V_DEF = 180;
    localparam int GRAD_W = 11;

    localparam logic [7:0] EDGE_CODE = 8'h00;
    localparam logic [7:0] BACK_CODE = 8'hFF;

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    // Weighted 1-2-1 sum of three pixels; max 1020 so it fits the gradient width unsigned
    function automatic logic [GRAD_W-1:0] wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return GRAD_W'(a) + (GRAD_W'(b) << 1) + GRAD_W'(c);
    endfunction

    function automatic logic [GRAD_W-1:0] abs_g(input logic signed [GRAD_W-1:0] v);
        return v[GRAD_W-1] ? GRAD_W'(-v) : GRAD_W'(v);
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: two-row line store with synchronous read-before-write; row r-1 cascades into row r-2
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = PIC_H_DEF,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    row1,
    output logic [7:0]    row2
);

    logic [7:0] mem1 [DEPTH];
    logic [7:0] mem2 [DEPTH];

    // Read both rows at this column, then push the new pixel down the column
    always_ff @(posedge clk) begin
        if (en) begin
            row1 <= mem1[addr];
            row2 <= mem2[addr];
            mem1[addr] <= wdata;
            mem2[addr] <= mem1[addr];
        end
    end

endmodule

// File: rtl/sobel_ctrl.sv
// sobel_ctrl: streaming 3x3 Sobel edge detector; define SOBEL_GRAY_OUT_EN for clipped magnitude output
module sobel_ctrl
    import sobel_pkg::*;
#(
    parameter int PIC_H = PIC_H_DEF,
    parameter int PIC_V = PIC_V_DEF,
    parameter logic [GRAD_W-1:0] THRESHOLD = 11'd100
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_done
);

    localparam int CW = $clog2(PIC_H);
    localparam int RW = $clog2(PIC_V);

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic col_last, row_last, out_ok;
    state_t state, state_nxt;

    logic [7:0] rd1, rd2, pix1;
    logic v1, ok1, last1, v2, last2;
    logic [2:0][7:0] wa, wb, nc;
    logic signed [GRAD_W-1:0] gx, gy;
    logic [GRAD_W-1:0] mag;
    logic [7:0] res;

    assign col_last = col_cnt == CW'(PIC_H - 1);
    assign row_last = row_cnt == RW'(PIC_V - 1);

    // Raster position of the incoming pixel; only moves on valid input
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (pi_flag) begin
            col_cnt <= col_last ? '0 : col_cnt + 1'b1;
            if (col_last)
                row_cnt <= row_last ? '0 : row_cnt + 1'b1;
        end
    end

    // Frame state register
    always_ff @(posedge sys_clk) begin
        state <= sys_rst ? FILL : state_nxt;
    end

    // RUN once two full rows are buffered; back to FILL after the last pixel of the frame
    always_comb begin
        state_nxt = state;
        out_ok = (state == RUN) && (col_cnt >= CW'(2));
        if (pi_flag && col_last) begin
            if (state == FILL && row_cnt == RW'(1))
                state_nxt = RUN;
            if (state == RUN && row_last)
                state_nxt = FILL;
        end
    end

    sobel_line_buf #(
        .DEPTH(PIC_H),
        .AW   (CW)
    ) u_line_buf (
        .clk  (sys_clk),
        .en   (pi_flag),
        .addr (col_cnt),
        .wdata(pi_data),
        .row1 (rd1),
        .row2 (rd2)
    );

    // Stage 1: newest column arrives (two rows from the buffer plus the delayed live pixel)
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            v1 <= 1'b0;
            ok1 <= 1'b0;
            last1 <= 1'b0;
        end else begin
            v1 <= pi_flag;
            ok1 <= pi_flag & out_ok;
            last1 <= pi_flag & row_last & col_last;
        end
        if (pi_flag)
            pix1 <= pi_data;
    end

    assign nc = {pix1, rd1, rd2};

    // Stage 2: gradients over {wa, wb, nc} (oldest to newest column), then shift the window
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            v2 <= 1'b0;
            last2 <= 1'b0;
        end else begin
            v2 <= ok1;
            last2 <= ok1 & last1;
        end
        if (v1) begin
            wa <= wb;
            wb <= nc;
            gx <= wsum(nc[0], nc[1], nc[2]) - wsum(wa[0], wa[1], wa[2]);
            gy <= wsum(wa[2], wb[2], nc[2]) - wsum(wa[0], wb[0], nc[0]);
        end
    end

    assign mag = abs_g(gx) + abs_g(gy);

`ifdef SOBEL_GRAY_OUT_EN
    assign res = (mag > GRAD_W'(255)) ? 8'hFF : mag[7:0];
`else
    assign res = (mag >= THRESHOLD) ? EDGE_CODE : BACK_CODE;
`endif

    // Stage 3: registered result; po_data holds between valid outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            po_flag <= 1'b0;
            frame_done <= 1'b0;
            po_data <= 8'h00;
        end else begin
            po_flag <= v2;
            frame_done <= v2 & last2;
            if (v2)
                po_data <= res;
        end
    end

endmodule

// File: tb/tb_sobel_ctrl.sv
// tb_sobel_ctrl: randomized scoreboard bench for sobel_ctrl against an image-array Sobel model
module tb_sobel_ctrl;

    localparam int H = 32;
    localparam int V = 20;
    localparam int NOUT = (H - 2) * (V - 2);
    localparam int EDGE_N = 2 * (V - 2);
`ifdef SOBEL_GRAY_OUT_EN
    localparam logic [7:0] FLAT = 8'h00;
`else
    localparam logic [7:0] FLAT = 8'hFF;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pi_flag = 1'b0;
    logic [7:0] pi_data = 8'h00;
    logic [7:0] po_data;
    logic po_flag;
    logic frame_done;

    int tests = 0;
    int fails = 0;
    int out_cnt = 0;
    int fd_cnt = 0;
    int flat_cnt = 0;
    int exp_q[$];
    int img [V][H];
    int mr = 0;
    int mc = 0;

    sobel_ctrl #(
        .PIC_H    (H),
        .PIC_V    (V),
        .THRESHOLD(11'd100)
    ) dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .pi_data   (pi_data),
        .pi_flag   (pi_flag),
        .po_data   (po_data),
        .po_flag   (po_flag),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic model_pixel(input logic [7:0] d);
        int gx, gy, mag, exp_d;
        img[mr][mc] = d;
        if (mr >= 2 && mc >= 2) begin
            gx = (img[mr-2][mc] + 2 * img[mr-1][mc] + img[mr][mc])
               - (img[mr-2][mc-2] + 2 * img[mr-1][mc-2] + img[mr][mc-2]);
            gy = (img[mr][mc-2] + 2 * img[mr][mc-1] + img[mr][mc])
               - (img[mr-2][mc-2] + 2 * img[mr-2][mc-1] + img[mr-2][mc]);
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_GRAY_OUT_EN
            exp_d = mag > 255 ? 255 : mag;
`else
            exp_d = mag >= 100 ? 0 : 255;
`endif
            exp_q.push_back(((mr == V - 1 && mc == H - 1) ? 256 : 0) + exp_d);
        end
        mc++;
        if (mc == H) begin
            mc = 0;
            mr = (mr == V - 1) ? 0 : mr + 1;
        end
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        model_pixel(d);
        pi_data = d;
        pi_flag = 1'b1;
        @(posedge clk);
        #1 pi_flag = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pixels(input int mode, input int n, input int max_gap);
        logic [7:0] d;
        int gap;
        for (int i = 0; i < n; i++) begin
            d = mode == 0 ? 8'h80 : mode == 1 ? (mc < H / 2 ? 8'h00 : 8'hFF) : 8'($urandom);
            gap = (max_gap > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, max_gap)) : 0;
            send(d, gap);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_eq(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pi_flag = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_po_flag", int'(po_flag), 0);
        check_eq("rst_po_data", int'(po_data), 0);
        check_eq("rst_frame_done", int'(frame_done), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        mr = 0;
        mc = 0;
    endtask

    task automatic monitor();
        int e;
        logic [7:0] last_d;
        last_d = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_d = 8'h00;
            end else if (po_flag) begin
                out_cnt++;
                if (frame_done) fd_cnt++;
                if (po_data == FLAT) flat_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL stale_out: po_flag with nothing expected, po_data=%h fd=%0b", po_data, frame_done);
                end else begin
                    e = exp_q.pop_front();
                    if ({frame_done, po_data} != 9'(e)) begin
                        fails++;
                        $display("FAIL pixel_%0d: got fd=%0b data=%h, want fd=%0b data=%h",
                                 out_cnt, frame_done, po_data, e[8], e[7:0]);
                    end
                end
                last_d = po_data;
            end else begin
                if (frame_done) begin
                    tests++;
                    fails++;
                    $display("FAIL lone_frame_done: frame_done=1 with po_flag=0");
                end
                if (po_data != last_d) begin
                    tests++;
                    fails++;
                    $display("FAIL hold_po_data: got %h, want %h", po_data, last_d);
                end
            end
        end
    endtask

    initial begin
        int b_out, b_fd, b_flat, lat;
        fork
            monitor();
            begin
                #2_000_000;
                $display("FAIL timeout: simulation did not finish, got %0d outputs", out_cnt);
                $fatal(1, "timeout");
            end
        join_none

        do_reset();

        b_out = out_cnt; b_fd = fd_cnt; b_flat = flat_cnt;
        send_pixels(0, H * V, 0);
        drain("drain_const");
        check_eq("const_outputs", out_cnt - b_out, NOUT);
        check_eq("const_frame_done", fd_cnt - b_fd, 1);
        check_eq("const_flat", flat_cnt - b_flat, NOUT);

        b_out = out_cnt; b_fd = fd_cnt; b_flat = flat_cnt;
        send_pixels(1, H * V, 0);
        drain("drain_step");
        check_eq("step_outputs", out_cnt - b_out, NOUT);
        check_eq("step_frame_done", fd_cnt - b_fd, 1);
        check_eq("step_flat", flat_cnt - b_flat, NOUT - EDGE_N);

        do_reset();
        send_pixels(2, 2 * H + 2, 0);
        send(8'($urandom), 0);
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (po_flag) lat = i;
        end
        check_eq("first_window_latency", lat, 3);
        send_pixels(2, 300 - (2 * H + 3), 0);
        drain("drain_partial");

        do_reset();
        b_out = out_cnt; b_fd = fd_cnt;
        send_pixels(2, H * V, 0);
        drain("drain_after_reset");
        check_eq("post_reset_outputs", out_cnt - b_out, NOUT);
        check_eq("post_reset_frame_done", fd_cnt - b_fd, 1);

        b_out = out_cnt; b_fd = fd_cnt;
        send_pixels(2, 2 * H * V, 4);
        drain("drain_gaps");
        check_eq("gap_outputs", out_cnt - b_out, 2 * NOUT);
        check_eq("gap_frame_done", fd_cnt - b_fd, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
